baud_tick_gen: RTL
==================

Name: baud_tick_gen

Overview:
- Programmable fractional baud-tick generator. Successor to the fixed-divisor oversample tick source.
- Produces an oversample tick at a runtime-selectable rate with fractional divisor accumulation.
- Also produces bit-boundary and mid-bit ticks derived from an internal oversample phase counter.
- Feeds UART TX/RX; RX uses sync to realign phase on start-bit detection.

Parameters:
- DIV_W, 16, width of integer divisor
- FRAC_W, 4, width of fractional divisor (units of 1/2^FRAC_W clock)
- OVERSAMPLE, 16, oversample ticks per bit; power of 2, >=4
- DEFAULT_DIV_INT, 162, active integer divisor after reset (50 MHz / (19200*16) = 162.76)
- DEFAULT_DIV_FRAC, 12, active fractional divisor after reset

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- en  in  1  count enable; low freezes all state
- sync  in  1  single-cycle phase restart request
- cfg_load  in  1  strobe: capture cfg_div_int/cfg_div_frac
- cfg_div_int  in  DIV_W  requested integer divisor
- cfg_div_frac  in  FRAC_W  requested fractional divisor
- tick_os  out  1  one-cycle oversample tick
- tick_bit  out  1  one-cycle tick, coincident with tick_os when os_phase wraps OVERSAMPLE-1 -> 0
- tick_mid  out  1  one-cycle tick, coincident with tick_os when os_phase becomes OVERSAMPLE/2
- os_phase  out  log2(OVERSAMPLE)  current oversample phase
- cfg_pending  out  1  loaded config not yet applied

Behaviour:
- Reset (async, rst=1): cnt=0, acc=0, os_phase=0, all ticks 0, cfg_pending=0, active divisor = DEFAULT_DIV_INT/DEFAULT_DIV_FRAC.
- All outputs are registered. Ticks are high for exactly one cycle and never high on consecutive cycles unless the period is 1.
- Effective integer divisor I = max(div_int, 1). Fraction F = div_frac.
- Period P = I + carry, where carry is latched at the previous wrap. The first period after reset, sync or config apply has carry=0.
- Counting, on each rising edge with en=1 and sync=0:
  - if cnt == P-1: wrap. Set cnt=0 and tick_os=1.
  - At wrap: acc(FRAC_W+1 bits) = acc[FRAC_W-1:0] + F. carry = acc MSB, used for the next period. os_phase increments modulo OVERSAMPLE.
  - Otherwise: cnt += 1, ticks 0.
- First tick_os is high after exactly P enabled edges.
- Example I=3, F=8 (FRAC_W=4): period sequence 3,3,4,3,4,3,4...
- en=0: cnt, acc, os_phase, carry hold; ticks 0. Config capture still works.
- sync=1 (priority over en and wrap): next edge sets cnt=0, acc=0, carry=0, os_phase=0, ticks 0. Any pending config is applied and cfg_pending cleared. sync coincident with wrap: no tick is emitted.
- cfg_load=1: capture the cfg inputs into pending registers and set cfg_pending=1. A new load while pending overwrites the earlier values.
- Config apply happens at the next wrap edge or sync edge:
  - active <= pending; acc=0; carry=0; cfg_pending=0.
  - The wrap's tick still fires. The new divisor governs the following period.
- cfg_load coincident with an apply edge: the values on the cfg inputs in that cycle are applied directly; cfg_pending=0 afterwards.
- Width rules:
  - cnt is DIV_W+1 bits, so P = 2^DIV_W-1+1 does not overflow.
  - Period comparison is done in DIV_W+1 bits.
  - cfg_div_int=0 behaves as 1.
- Reset asserted mid-period: all state returns to reset values immediately, independent of clk.

Test Plan:
- Reset release, en=1, defaults: tick_os intervals are 162 or 163 clocks. Over 16 ticks the total is 2604 clocks ±1. tick_bit fires on every 16th tick_os. tick_mid fires on the tick_os that sets os_phase=8.
- cfg_load I=3, F=8, then sync: tick_os intervals are 3,3,4,3,4,3,4. cfg_pending is 1 from the load until the sync edge.
- I=1, F=0: tick_os is high every enabled cycle. os_phase cycles 0..15, and tick_bit fires once per 16 cycles.
- en dropped for 10 cycles mid-period with I=5: the tick is delayed by exactly 10 cycles, and os_phase does not change while en=0.
- sync asserted on a wrap cycle: no tick_os that cycle. The next tick_os follows exactly I enabled edges later, with os_phase=1.
- rst pulsed asynchronously between clock edges mid-count: outputs go to 0 immediately. The active divisor is back to 162/12 and the first tick_os occurs 162 edges after release.

Source files
------------

// File: rtl/baud_tick_gen.sv
// Programmable fractional baud-tick generator: oversample, bit-boundary and mid-bit ticks
// with runtime divisor reload and phase resynchronisation.
module baud_tick_gen #(
  parameter int unsigned DIV_W            = 16,
  parameter int unsigned FRAC_W           = 4,
  parameter int unsigned OVERSAMPLE       = 16,
  parameter int unsigned DEFAULT_DIV_INT  = 162,
  parameter int unsigned DEFAULT_DIV_FRAC = 12
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          sync,
  input  logic                          cfg_load,
  input  logic [DIV_W-1:0]              cfg_div_int,
  input  logic [FRAC_W-1:0]             cfg_div_frac,
  output logic                          tick_os,
  output logic                          tick_bit,
  output logic                          tick_mid,
  output logic [$clog2(OVERSAMPLE)-1:0] os_phase,
  output logic                          cfg_pending
);

  localparam int unsigned PH_W  = $clog2(OVERSAMPLE);
  localparam int unsigned CNT_W = DIV_W + 1;
  localparam int unsigned ACC_W = FRAC_W + 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(OVERSAMPLE - 1);
  localparam logic [PH_W-1:0] PH_MID  = PH_W'(OVERSAMPLE / 2);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [FRAC_W-1:0] acc_q, acc_d;
  logic              carry_q, carry_d;
  logic [DIV_W-1:0]  div_int_q, div_int_d;
  logic [FRAC_W-1:0] div_frac_q, div_frac_d;
  logic [DIV_W-1:0]  pend_int_q, pend_int_d;
  logic [FRAC_W-1:0] pend_frac_q, pend_frac_d;
  logic [PH_W-1:0]   phase_d;
  logic              tick_os_d, tick_bit_d, tick_mid_d, pending_d;

  logic [DIV_W-1:0]  eff_int;
  logic [CNT_W-1:0]  period;
  logic [ACC_W-1:0]  acc_sum;
  logic [PH_W-1:0]   phase_inc;
  logic              wrap, apply;
  logic [DIV_W-1:0]  new_int;
  logic [FRAC_W-1:0] new_frac;

  // Period arithmetic; a zero divisor is treated as one
  always_comb begin
    eff_int   = (div_int_q == '0) ? DIV_W'(1) : div_int_q;
    period    = CNT_W'(eff_int) + CNT_W'(carry_q);
    wrap      = (cnt_q == period - CNT_W'(1));
    acc_sum   = ACC_W'(acc_q) + ACC_W'(div_frac_q);
    phase_inc = os_phase + PH_W'(1);
    apply     = cfg_load | cfg_pending;
    new_int   = cfg_load ? cfg_div_int  : pend_int_q;
    new_frac  = cfg_load ? cfg_div_frac : pend_frac_q;
  end

  // Next-state: sync beats wrap, wrap beats plain counting
  always_comb begin
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    carry_d     = carry_q;
    div_int_d   = div_int_q;
    div_frac_d  = div_frac_q;
    pend_int_d  = pend_int_q;
    pend_frac_d = pend_frac_q;
    phase_d     = os_phase;
    pending_d   = cfg_pending;
    tick_os_d   = 1'b0;
    tick_bit_d  = 1'b0;
    tick_mid_d  = 1'b0;

    if (cfg_load) begin
      pend_int_d  = cfg_div_int;
      pend_frac_d = cfg_div_frac;
    end

    if (sync) begin
      cnt_d     = '0;
      acc_d     = '0;
      carry_d   = 1'b0;
      phase_d   = '0;
      pending_d = 1'b0;
      if (apply) begin
        div_int_d  = new_int;
        div_frac_d = new_frac;
      end
    end else if (en && wrap) begin
      cnt_d      = '0;
      tick_os_d  = 1'b1;
      tick_bit_d = (os_phase == PH_LAST);
      tick_mid_d = (phase_inc == PH_MID);
      phase_d    = phase_inc;
      if (apply) begin
        // New divisor starts a clean period with no fractional history
        div_int_d  = new_int;
        div_frac_d = new_frac;
        acc_d      = '0;
        carry_d    = 1'b0;
        pending_d  = 1'b0;
      end else begin
        acc_d   = acc_sum[FRAC_W-1:0];
        carry_d = acc_sum[FRAC_W];
      end
    end else begin
      if (en) cnt_d = cnt_q + CNT_W'(1);
      if (cfg_load) pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      acc_q       <= '0;
      carry_q     <= 1'b0;
      div_int_q   <= DIV_W'(DEFAULT_DIV_INT);
      div_frac_q  <= FRAC_W'(DEFAULT_DIV_FRAC);
      pend_int_q  <= DIV_W'(DEFAULT_DIV_INT);
      pend_frac_q <= FRAC_W'(DEFAULT_DIV_FRAC);
      os_phase    <= '0;
      cfg_pending <= 1'b0;
      tick_os     <= 1'b0;
      tick_bit    <= 1'b0;
      tick_mid    <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      carry_q     <= carry_d;
      div_int_q   <= div_int_d;
      div_frac_q  <= div_frac_d;
      pend_int_q  <= pend_int_d;
      pend_frac_q <= pend_frac_d;
      os_phase    <= phase_d;
      cfg_pending <= pending_d;
      tick_os     <= tick_os_d;
      tick_bit    <= tick_bit_d;
      tick_mid    <= tick_mid_d;
    end
  end

endmodule
